// File: rtl/stream_pkg.sv
// -----------------------------------------------------------------------------
// stream_pkg
// Shared types and helpers for the stream width converters (serializer now,
// deserializer later).
//   ser_state_e    : serializer FSM states
//   nbeats_decode  : beat-count field to beat count (0 encodes the full ratio)
//   ser_params_ok  : legality check for the IN_W / RATIO parameter pair
// -----------------------------------------------------------------------------
package stream_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } ser_state_e;

    // A zero field means "all RATIO beats"; any other value is the beat count.
    function automatic int unsigned nbeats_decode(input int unsigned enc,
                                                  input int unsigned ratio);
        int unsigned n;
        if (enc == 32'd0) begin
            n = ratio;
        end else begin
            n = enc;
        end
        return n;
    endfunction

    // Word width must split evenly and there must be at least two beats.
    function automatic bit ser_params_ok(input int unsigned in_w,
                                         input int unsigned ratio);
        return (ratio >= 32'd2) && ((in_w % ratio) == 32'd0);
    endfunction

endpackage

// File: rtl/stream_serializer_shift_reg.sv
// -----------------------------------------------------------------------------
// serializer_shift_reg
// Parallel-load shift register that presents one OUT_W slice at a time.
// MSB_FIRST=0 shifts right and presents the low slice; MSB_FIRST=1 shifts left
// and presents the high slice. Load has priority over shift; neither holds.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_load, i_data : load a new IN_W word
//   i_shift        : advance to the next slice
//   o_beat         : current slice (straight from the register)
// -----------------------------------------------------------------------------
module serializer_shift_reg #(
    parameter int IN_W      = 32,
    parameter int OUT_W     = 8,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_load,
    input  logic [IN_W-1:0]  i_data,
    input  logic             i_shift,
    output logic [OUT_W-1:0] o_beat
);

    logic [IN_W-1:0] r_data;
    logic [IN_W-1:0] w_shifted;

    // Next contents after one slice has been consumed.
    always_comb begin
        w_shifted = '0;
        if (MSB_FIRST) begin
            w_shifted = {r_data[IN_W-OUT_W-1:0], {OUT_W{1'b0}}};
        end else begin
            w_shifted = {{OUT_W{1'b0}}, r_data[IN_W-1:OUT_W]};
        end
    end

    // Word storage: load, shift or hold.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_data <= '0;
        end else if (i_load) begin
            r_data <= i_data;
        end else if (i_shift) begin
            r_data <= w_shifted;
        end else begin
            r_data <= r_data;
        end
    end

    generate
        if (MSB_FIRST) begin : g_msb
            assign o_beat = r_data[IN_W-1 -: OUT_W];
        end else begin : g_lsb
            assign o_beat = r_data[OUT_W-1:0];
        end
    endgenerate

endmodule

// File: rtl/stream_serializer.sv
// -----------------------------------------------------------------------------
// stream_serializer
// Splits each IN_W word into up to RATIO OUT_W beats with ready/valid on both
// sides and no bubble between words. Build option STREAM_SERIALIZER_MSB_FIRST_EN
// emits the most-significant slice first; default is least-significant first.
//   clk_i, rst_ni            : clock, asynchronous active-low reset
//   in_data_i, in_nbeats_i   : word and beat count (0 = RATIO beats)
//   in_valid_i / in_ready_o  : input handshake
//   out_data_o, out_last_o   : current beat, final-beat flag
//   out_valid_o / out_ready_i: output handshake
// in_ready_o depends combinationally on out_ready_i so the next word can be
// taken in the same cycle the last beat leaves.
// -----------------------------------------------------------------------------
module stream_serializer
    import stream_pkg::*;
#(
    parameter  int IN_W  = 32,
    parameter  int RATIO = 4,
    localparam int OUT_W = IN_W / RATIO,
    localparam int CNT_W = $clog2(RATIO)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [IN_W-1:0]  in_data_i,
    input  logic [CNT_W-1:0] in_nbeats_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    output logic [OUT_W-1:0] out_data_o,
    output logic             out_last_o,
    output logic             out_valid_o,
    input  logic             out_ready_i
);

`ifdef STREAM_SERIALIZER_MSB_FIRST_EN
    localparam bit MSB_FIRST = 1'b1;
`else
    localparam bit MSB_FIRST = 1'b0;
`endif

    localparam bit PARAMS_OK = ser_params_ok(IN_W, RATIO);

    generate
        if (!PARAMS_OK) begin : g_bad_params
            $error("stream_serializer: IN_W must be a multiple of RATIO and RATIO >= 2");
        end
    endgenerate

    ser_state_e       r_state;
    ser_state_e       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_last_idx;
    logic [CNT_W-1:0] w_last_idx_in;
    logic             w_last;
    logic             w_out_fire;
    logic             w_in_fire;
    logic             w_load;
    logic             w_shift;

    // Index of the final beat, kept instead of the raw count so that a full
    // word (field 0) never needs a value wider than CNT_W.
    assign w_last_idx_in = CNT_W'(nbeats_decode(32'(in_nbeats_i), RATIO) - 32'd1);

    assign out_valid_o = (r_state == BUSY);
    assign w_last      = (r_cnt == r_last_idx);
    assign out_last_o  = out_valid_o & w_last;
    assign w_out_fire  = out_valid_o & out_ready_i;
    assign in_ready_o  = (r_state == IDLE) | (out_valid_o & w_last & out_ready_i);
    assign w_in_fire   = in_valid_i & in_ready_o;

    // Next state plus load/shift strobes for the datapath.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_shift     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_in_fire) begin
                    w_load      = 1'b1;
                    w_state_nxt = BUSY;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            BUSY: begin
                if (w_out_fire) begin
                    if (w_last) begin
                        if (w_in_fire) begin
                            w_load      = 1'b1;
                            w_state_nxt = BUSY;
                        end else begin
                            w_state_nxt = IDLE;
                        end
                    end else begin
                        w_shift = 1'b1;
                    end
                end else begin
                    w_state_nxt = BUSY;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Beat counter and final-beat index, captured on every word load.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cnt      <= '0;
            r_last_idx <= '0;
        end else if (w_load) begin
            r_cnt      <= '0;
            r_last_idx <= w_last_idx_in;
        end else if (w_shift) begin
            r_cnt      <= r_cnt + CNT_W'(1);
            r_last_idx <= r_last_idx;
        end else begin
            r_cnt      <= r_cnt;
            r_last_idx <= r_last_idx;
        end
    end

    serializer_shift_reg #(
        .IN_W      (IN_W),
        .OUT_W     (OUT_W),
        .MSB_FIRST (MSB_FIRST)
    ) u_shift_reg (
        .i_clk   (clk_i),
        .i_rst_n (rst_ni),
        .i_load  (w_load),
        .i_data  (in_data_i),
        .i_shift (w_shift),
        .o_beat  (out_data_o)
    );

endmodule

// File: tb/tb_stream_serializer.sv
// -----------------------------------------------------------------------------
// tb_stream_serializer
// Directed bench for stream_serializer (IN_W=32, RATIO=4). Inputs are driven
// on the falling edge, outputs sampled 1 time unit later.
// -----------------------------------------------------------------------------
module tb_stream_serializer;

    logic        clk;
    logic        rst_n;
    logic [31:0] in_data;
    logic [1:0]  in_nbeats;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  out_data;
    logic        out_last;
    logic        out_valid;
    logic        out_ready;

    int n_pass;
    int n_total;

    typedef struct {
        string       name;
        logic [31:0] data;
        logic [1:0]  nb;
        int          n;
        logic [31:0] beats;   // expected beat k in bits [8k+7:8k]
    } vec_t;

    vec_t vecs[4];

    stream_serializer #(.IN_W(32), .RATIO(4)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .in_data_i   (in_data),
        .in_nbeats_i (in_nbeats),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .out_data_o  (out_data),
        .out_last_o  (out_last),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Expected byte for beat i of the back-to-back pair 04030201 / 08070605.
    function automatic logic [7:0] b2b_exp(input int i);
`ifdef STREAM_SERIALIZER_MSB_FIRST_EN
        return 8'((i / 4) * 4 + 4 - (i % 4));
`else
        return 8'(i + 1);
`endif
    endfunction

    task automatic run_vec(input vec_t v);
        logic [31:0] bt;
        bt = v.beats;
        @(negedge clk);
        in_data   = v.data;
        in_nbeats = v.nb;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1 chk({v.name, " in_ready idle"}, 32'(in_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        for (int k = 0; k < v.n; k++) begin
            #1;
            chk({v.name, " valid"}, 32'(out_valid), 32'd1);
            chk({v.name, " data"}, 32'(out_data), 32'(bt[8*k +: 8]));
            chk({v.name, " last"}, 32'(out_last), 32'(k == v.n - 1));
            @(posedge clk);
            @(negedge clk);
        end
        #1;
        chk({v.name, " valid after"}, 32'(out_valid), 32'd0);
        chk({v.name, " ready after"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        int           k;
        logic [31:0]  bp_exp;
        logic [3:0]   bp_pat;
        logic [7:0]   b2b_word[2];

        n_pass    = 0;
        n_total   = 0;
        rst_n     = 1'b0;
        in_data   = 32'h0;
        in_nbeats = 2'd0;
        in_valid  = 1'b0;
        out_ready = 1'b0;

`ifdef STREAM_SERIALIZER_MSB_FIRST_EN
        vecs[0] = '{"full",  32'hDDCC_BBAA, 2'd0, 4, 32'hAABB_CCDD};
        vecs[1] = '{"nb2",   32'h1122_3344, 2'd2, 2, 32'h0000_2211};
        vecs[2] = '{"nb1",   32'hCAFE_F00D, 2'd1, 1, 32'h0000_00CA};
        vecs[3] = '{"nb3",   32'h8899_AABB, 2'd3, 3, 32'h00AA_9988};
        bp_exp  = 32'hAABB_CCDD;
`else
        vecs[0] = '{"full",  32'hDDCC_BBAA, 2'd0, 4, 32'hDDCC_BBAA};
        vecs[1] = '{"nb2",   32'h1122_3344, 2'd2, 2, 32'h0000_3344};
        vecs[2] = '{"nb1",   32'hCAFE_F00D, 2'd1, 1, 32'h0000_000D};
        vecs[3] = '{"nb3",   32'h8899_AABB, 2'd3, 3, 32'h0099_AABB};
        bp_exp  = 32'hDDCC_BBAA;
`endif

        // Reset state, then idle for 10 cycles.
        #12;
        chk("reset data", 32'(out_data), 32'h0);
        chk("reset last", 32'(out_last), 32'd0);
        rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            #1;
            chk("idle valid", 32'(out_valid), 32'd0);
            chk("idle ready", 32'(in_ready), 32'd1);
        end

        // Table-driven single words.
        for (int i = 0; i < 4; i++) begin
            run_vec(vecs[i]);
        end

        // Back-to-back full words with in_valid held high.
        b2b_word[0] = 8'h00;
        b2b_word[1] = 8'h00;
        @(negedge clk);
        in_data   = 32'h0403_0201;
        in_nbeats = 2'd0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_data = 32'h0807_0605;
        for (int i = 0; i < 8; i++) begin
            #1;
            chk("b2b valid", 32'(out_valid), 32'd1);
            chk("b2b data", 32'(out_data), 32'(b2b_exp(i)));
            chk("b2b last", 32'(out_last), 32'(i == 3 || i == 7));
            chk("b2b in_ready", 32'(in_ready), 32'(i == 3 || i == 7));
            @(posedge clk);
            @(negedge clk);
            if (i == 3) begin
                in_valid = 1'b0;
            end
        end
        #1 chk("b2b valid after", 32'(out_valid), 32'd0);

        // Backpressure: out_ready pattern 1,0,0,1 then held high.
        bp_pat = 4'b1001;   // bit c = out_ready in cycle c
        @(negedge clk);
        in_data   = 32'hDDCC_BBAA;
        in_nbeats = 2'd0;
        in_valid  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        k = 0;
        for (int c = 0; c < 20 && k < 4; c++) begin
            out_ready = (c < 4) ? bp_pat[c] : 1'b1;
            #1;
            chk("bp valid", 32'(out_valid), 32'd1);
            chk("bp data", 32'(out_data), 32'(bp_exp[8*k +: 8]));
            chk("bp last", 32'(out_last), 32'(k == 3));
            @(posedge clk);
            if (out_ready) begin
                k++;
            end
            @(negedge clk);
        end
        chk("bp beats done", 32'(k), 32'd4);
        #1 chk("bp valid after", 32'(out_valid), 32'd0);

        // Mid-word reset after two beats of four.
        @(negedge clk);
        in_data   = 32'h5566_7788;
        in_nbeats = 2'd0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        chk("pre-reset valid", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("async reset valid", 32'(out_valid), 32'd0);
        chk("async reset ready", 32'(in_ready), 32'd1);
        chk("async reset data", 32'(out_data), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            #1 chk("post-reset no beat", 32'(out_valid), 32'd0);
        end

        // Fresh word after the reset comes out normally.
        run_vec(vecs[1]);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
